// File: rtl/am_query_arbiter_pkg.sv
// Shared types, defaults and helpers for the associative-memory query arbiter.
package am_query_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RES = 2'd2,
        ARB_DELIVER  = 2'd3
    } arb_state_e;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // (base + offset) mod modulus, assuming base and offset are both < modulus.
    function automatic int wrap_index(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        return (sum >= modulus) ? (sum - modulus) : sum;
    endfunction

    localparam int AM_ARB_NUM_REQ        = 4;
    localparam int AM_ARB_TAG_WIDTH      = ceil_log2(AM_ARB_NUM_REQ);
    localparam int AM_ARB_HV_DIMENSION   = 2000;
    localparam int AM_ARB_LABEL_WIDTH    = 1;
    localparam int AM_ARB_DISTANCE_WIDTH = 11;

endpackage

// File: rtl/am_query_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above the
// pointer, wrapping to index 0. With the pointer tied to 0 it degenerates to
// fixed lowest-index priority.
module rr_arbiter
    import am_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = AM_ARB_NUM_REQ,
    parameter int TAG_WIDTH = AM_ARB_TAG_WIDTH
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [TAG_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic [TAG_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    // Search upward from the pointer; the first hit wins.
    always_comb begin : grant_search
        int sel;
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        sel          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = wrap_index(int'(ptr), k, NUM_REQ);
            if (!grant_valid && req[sel]) begin
                grant_valid       = 1'b1;
                grant_idx         = TAG_WIDTH'(sel);
                grant_onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am_query_arbiter.sv
// Shares one non-pipelined associative memory between NUM_REQ query sources.
// One query in flight: grant -> issue to AM -> wait for result -> deliver
// the tagged result downstream, then back to idle (one bubble per query).
// Build option: define AM_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no pointer register); otherwise requesters are served round-robin.
module am_query_arbiter
    import am_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = AM_ARB_NUM_REQ,
    parameter int TAG_WIDTH      = AM_ARB_TAG_WIDTH,
    parameter int HV_DIMENSION   = AM_ARB_HV_DIMENSION,
    parameter int LABEL_WIDTH    = AM_ARB_LABEL_WIDTH,
    parameter int DISTANCE_WIDTH = AM_ARB_DISTANCE_WIDTH
) (
    input  logic                              Clk_CI,
    input  logic                              Reset_RI,
    // Requester side
    input  logic [NUM_REQ-1:0]                ValidIn_SI,
    output logic [NUM_REQ-1:0]                ReadyOut_SO,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]   HypervectorIn_DI,
    // AM query side
    output logic                              AmValid_SO,
    input  logic                              AmReady_SI,
    output logic [HV_DIMENSION-1:0]           AmHypervector_DO,
    // AM result side
    input  logic                              AmValidOut_SI,
    output logic                              AmReadyIn_SO,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_A_DI,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_V_DI,
    // Downstream result side
    output logic                              ValidOut_SO,
    input  logic                              ReadyIn_SI,
    output logic [TAG_WIDTH-1:0]              TagOut_DO,
    output logic [LABEL_WIDTH-1:0]            LabelOut_A_DO,
    output logic [LABEL_WIDTH-1:0]            LabelOut_V_DO,
    output logic [DISTANCE_WIDTH-1:0]         DistanceOut_A_DO,
    output logic [DISTANCE_WIDTH-1:0]         DistanceOut_V_DO,
    output logic                              Busy_SO
);

    arb_state_e                  state_q, state_d;
    logic [HV_DIMENSION-1:0]     query_q, query_d;
    logic [TAG_WIDTH-1:0]        tag_q, tag_d;
    logic [LABEL_WIDTH-1:0]      label_a_q, label_a_d;
    logic [LABEL_WIDTH-1:0]      label_v_q, label_v_d;
    logic [DISTANCE_WIDTH-1:0]   distance_a_q, distance_a_d;
    logic [DISTANCE_WIDTH-1:0]   distance_v_q, distance_v_d;

    logic [TAG_WIDTH-1:0]        arb_ptr;
    logic [NUM_REQ-1:0]          grant_onehot;
    logic [TAG_WIDTH-1:0]        grant_idx;
    logic                        grant_valid;
    logic [HV_DIMENSION-1:0]     grant_query;

`ifdef AM_ARB_FIXED_PRIO_EN
    // Fixed priority: search always starts at requester 0.
    assign arb_ptr = '0;
`else
    logic [TAG_WIDTH-1:0]        ptr_q, ptr_d;
    assign arb_ptr = ptr_q;
`endif

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rr_arbiter (
        .req          (ValidIn_SI),
        .ptr          (arb_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    // Select the granted requester's hypervector slice.
    always_comb begin
        grant_query = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                grant_query = HypervectorIn_DI[i*HV_DIMENSION +: HV_DIMENSION];
            end
        end
    end

    // Next-state, capture logic and handshake outputs.
    always_comb begin
        state_d      = state_q;
        query_d      = query_q;
        tag_d        = tag_q;
        label_a_d    = label_a_q;
        label_v_d    = label_v_q;
        distance_a_d = distance_a_q;
        distance_v_d = distance_v_q;
`ifndef AM_ARB_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        ReadyOut_SO  = '0;
        AmValid_SO   = 1'b0;
        AmReadyIn_SO = 1'b0;
        ValidOut_SO  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                ReadyOut_SO = grant_onehot;
                if (grant_valid) begin
                    query_d = grant_query;
                    tag_d   = grant_idx;
`ifndef AM_ARB_FIXED_PRIO_EN
                    // Wrap explicitly so a non-power-of-two NUM_REQ never yields an out-of-range pointer.
                    ptr_d   = (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + TAG_WIDTH'(1);
`endif
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                AmValid_SO = 1'b1;
                if (AmReady_SI) begin
                    state_d = ARB_WAIT_RES;
                end
            end
            ARB_WAIT_RES: begin
                AmReadyIn_SO = 1'b1;
                if (AmValidOut_SI) begin
                    label_a_d    = AmLabel_A_DI;
                    label_v_d    = AmLabel_V_DI;
                    distance_a_d = AmDistance_A_DI;
                    distance_v_d = AmDistance_V_DI;
                    state_d      = ARB_DELIVER;
                end
            end
            ARB_DELIVER: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q      <= ARB_IDLE;
            // NOTE: the query buffer is an ordinary register, so it is cleared on reset and the AM never sees stale data.
            query_q      <= '0;
            tag_q        <= '0;
            label_a_q    <= '0;
            label_v_q    <= '0;
            distance_a_q <= '0;
            distance_v_q <= '0;
`ifndef AM_ARB_FIXED_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q      <= state_d;
            query_q      <= query_d;
            tag_q        <= tag_d;
            label_a_q    <= label_a_d;
            label_v_q    <= label_v_d;
            distance_a_q <= distance_a_d;
            distance_v_q <= distance_v_d;
`ifndef AM_ARB_FIXED_PRIO_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign AmHypervector_DO = query_q;
    assign TagOut_DO        = tag_q;
    assign LabelOut_A_DO    = label_a_q;
    assign LabelOut_V_DO    = label_v_q;
    assign DistanceOut_A_DO = distance_a_q;
    assign DistanceOut_V_DO = distance_v_q;
    assign Busy_SO          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_am_query_arbiter.sv
// Self-checking bench for am_query_arbiter: a transaction-level reference
// model checks every output on every cycle, directed sequences pin the model
// with literal values, and a randomized phase exercises handshakes and resets.
// A second, 3-requester instance covers pointer wrap for non-power-of-two sizes.
module tb_am_query_arbiter;

    localparam int N   = 4;
    localparam int TW  = 2;
    localparam int HV  = 2000;
    localparam int LW  = 1;
    localparam int DW  = 11;
    localparam int N3  = 3;
    localparam int HV3 = 16;
`ifdef AM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    valid_in, ready_out;
    logic [N*HV-1:0] hv_in;
    logic            am_valid, am_ready, am_vout, am_rin;
    logic [HV-1:0]   am_hv;
    logic [LW-1:0]   la, lv, lao, lvo;
    logic [DW-1:0]   da, dv, dao, dvo;
    logic            valid_out, ready_in, busy;
    logic [TW-1:0]   tag;

    logic [N3-1:0]     valid3, ready3;
    logic [N3*HV3-1:0] hv3;
    logic              am_valid3, am_rin3, valid_out3, busy3;
    logic [HV3-1:0]    am_hv3;
    logic [LW-1:0]     lao3, lvo3;
    logic [DW-1:0]     dao3, dvo3;
    logic [TW-1:0]     tag3;

    int n_checks = 0;
    int n_fail   = 0;

    am_query_arbiter #(
        .NUM_REQ(N), .TAG_WIDTH(TW), .HV_DIMENSION(HV), .LABEL_WIDTH(LW), .DISTANCE_WIDTH(DW)
    ) dut (
        .Clk_CI(clk), .Reset_RI(rst),
        .ValidIn_SI(valid_in), .ReadyOut_SO(ready_out), .HypervectorIn_DI(hv_in),
        .AmValid_SO(am_valid), .AmReady_SI(am_ready), .AmHypervector_DO(am_hv),
        .AmValidOut_SI(am_vout), .AmReadyIn_SO(am_rin),
        .AmLabel_A_DI(la), .AmLabel_V_DI(lv), .AmDistance_A_DI(da), .AmDistance_V_DI(dv),
        .ValidOut_SO(valid_out), .ReadyIn_SI(ready_in), .TagOut_DO(tag),
        .LabelOut_A_DO(lao), .LabelOut_V_DO(lvo), .DistanceOut_A_DO(dao), .DistanceOut_V_DO(dvo),
        .Busy_SO(busy)
    );

    am_query_arbiter #(
        .NUM_REQ(N3), .TAG_WIDTH(TW), .HV_DIMENSION(HV3), .LABEL_WIDTH(LW), .DISTANCE_WIDTH(DW)
    ) dut3 (
        .Clk_CI(clk), .Reset_RI(rst),
        .ValidIn_SI(valid3), .ReadyOut_SO(ready3), .HypervectorIn_DI(hv3),
        .AmValid_SO(am_valid3), .AmReady_SI(1'b1), .AmHypervector_DO(am_hv3),
        .AmValidOut_SI(1'b1), .AmReadyIn_SO(am_rin3),
        .AmLabel_A_DI(1'b1), .AmLabel_V_DI(1'b0), .AmDistance_A_DI(11'd7), .AmDistance_V_DI(11'd9),
        .ValidOut_SO(valid_out3), .ReadyIn_SI(1'b1), .TagOut_DO(tag3),
        .LabelOut_A_DO(lao3), .LabelOut_V_DO(lvo3), .DistanceOut_A_DO(dao3), .DistanceOut_V_DO(dvo3),
        .Busy_SO(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_hv(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: low bits got 0x%0h expected 0x%0h (t=%0t)", name, act[63:0], exp[63:0], $time);
        end
    endtask

    // Inputs change only just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_hv();
        for (int w = 0; w < (N*HV)/32; w++) begin
            hv_in[w*32 +: 32] = $urandom;
        end
    endtask

    // ---------------- reference model ----------------
    // Phases follow the described lifecycle of one query.
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DELIVER = 3;

    int            m_phase;
    int            m_ptr;
    int            m_tag;
    logic [HV-1:0] m_query;
    logic [LW-1:0] m_la, m_lv;
    logic [DW-1:0] m_da, m_dv;
    bit            m_live = 1'b0;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model
        int           g;
        logic [N-1:0] exp_rdy;
        g = pick(valid_in, FIXED ? 0 : m_ptr);
        exp_rdy = '0;
        if (m_phase == P_IDLE && g >= 0) exp_rdy[g] = 1'b1;
        if (m_live) begin
            check("m_ready_out", 64'(ready_out), 64'(exp_rdy));
            check("m_busy", 64'(busy), 64'(m_phase != P_IDLE));
            check("m_am_valid", 64'(am_valid), 64'(m_phase == P_ISSUE));
            check("m_am_ready_in", 64'(am_rin), 64'(m_phase == P_WAIT));
            check("m_valid_out", 64'(valid_out), 64'(m_phase == P_DELIVER));
            check("m_tag", 64'(tag), 64'(m_tag));
            check("m_label_a", 64'(lao), 64'(m_la));
            check("m_label_v", 64'(lvo), 64'(m_lv));
            check("m_dist_a", 64'(dao), 64'(m_da));
            check("m_dist_v", 64'(dvo), 64'(m_dv));
            check_hv("m_am_hv", am_hv, m_query);
        end
        if (rst) begin
            m_phase = P_IDLE; m_ptr = 0; m_tag = 0; m_query = '0;
            m_la = '0; m_lv = '0; m_da = '0; m_dv = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                P_IDLE: if (g >= 0) begin
                    m_query = hv_in[g*HV +: HV];
                    m_tag   = g;
                    m_ptr   = (g + 1) % N;
                    m_phase = P_ISSUE;
                end
                P_ISSUE:   if (am_ready) m_phase = P_WAIT;
                P_WAIT:    if (am_vout) begin
                    m_la = la; m_lv = lv; m_da = da; m_dv = dv;
                    m_phase = P_DELIVER;
                end
                default:   if (ready_in) m_phase = P_IDLE;
            endcase
        end
    end

    // One full query from IDLE with an always-ready AM and downstream; reports the delivered tag.
    task automatic run_one(input logic [N-1:0] req, output int got_tag, output bit ok);
        valid_in = req; am_ready = 1'b1; am_vout = 1'b1; ready_in = 1'b1;
        fill_hv();
        ok = 1'b0; got_tag = -1;
        for (int c = 0; c < 16 && !ok; c++) begin
            @(negedge clk);
            if (valid_out) begin
                got_tag = int'(tag);
                ok = 1'b1;
            end
            tick();
            valid_in = '0;
        end
        am_ready = 1'b0; am_vout = 1'b0; ready_in = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int            grants, cyc, idx, got;
        bit            ok;
        logic [HV-1:0] q_exp, q2;
        logic [HV3-1:0] s3;

        rst = 1'b1; valid_in = '0; hv_in = '0; am_ready = 1'b0; am_vout = 1'b0;
        la = '0; lv = '0; da = '0; dv = '0; ready_in = 1'b0;
        valid3 = '0; hv3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_am_valid", 64'(am_valid), 64'd0);
        check("rst_am_ready_in", 64'(am_rin), 64'd0);
        check("rst_tag", 64'(tag), 64'd0);
        check("rst_dist_a", 64'(dao), 64'd0);
        check_hv("rst_am_hv", am_hv, '0);

        // Contention: all requesters valid for 8 grants
        tick();
        valid_in = 4'b1111; am_ready = 1'b1; am_vout = 1'b1; ready_in = 1'b1;
        fill_hv();
        grants = 0; cyc = 0;
        while (grants < 8 && cyc < 64) begin
            @(negedge clk);
            if (!busy && ready_out != '0) begin
                check("contention_onehot", 64'($countones(ready_out)), 64'd1);
                idx = -1;
                for (int i = 0; i < N; i++) if (ready_out[i]) idx = i;
                check("contention_grant", 64'(idx), FIXED ? 64'd0 : 64'(grants % N));
                grants++;
            end
            cyc++;
            tick();
            if (grants == 8) valid_in = '0;
        end
        check("contention_count", 64'(grants), 64'd8);
        repeat (4) tick();
        am_vout = 1'b0; ready_in = 1'b0; am_ready = 1'b0;

        // Single request from requester 2
        fill_hv();
        q_exp = hv_in[2*HV +: HV];
        valid_in = 4'b0100; am_ready = 1'b1;
        @(negedge clk);
        check("single_ready_out", 64'(ready_out), 64'h4);
        tick();
        valid_in = '0;
        @(negedge clk);
        check("single_am_valid", 64'(am_valid), 64'd1);
        check_hv("single_am_hv", am_hv, q_exp);
        tick();
        am_vout = 1'b1; la = 1'b1; lv = 1'b0; da = 11'd37; dv = 11'd912;
        @(negedge clk);
        check("single_am_ready_in", 64'(am_rin), 64'd1);
        tick();
        // Result offered again outside WAIT_RES must be ignored.
        la = 1'b0; lv = 1'b1; da = 11'd5; dv = 11'd6;
        valid_in = 4'b0011;
        fill_hv();
        q2 = hv_in[0 +: HV];

        // Backpressure: downstream stalls 20 cycles in DELIVER
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid_out", 64'(valid_out), 64'd1);
            check("bp_tag", 64'(tag), 64'd2);
            check("bp_label_a", 64'(lao), 64'd1);
            check("bp_label_v", 64'(lvo), 64'd0);
            check("bp_dist_a", 64'(dao), 64'd37);
            check("bp_dist_v", 64'(dvo), 64'd912);
            check("bp_ready_out", 64'(ready_out), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        am_vout = 1'b0; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        @(negedge clk);
        check("bp_release_idle", 64'(busy), 64'd0);
        check("bp_release_grant", 64'(ready_out), 64'h1);
        tick();
        valid_in = '0; am_ready = 1'b0;

        // AM stall: 5 cycles without AmReady in ISSUE
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_am_valid", 64'(am_valid), 64'd1);
            check("stall_am_ready_in", 64'(am_rin), 64'd0);
            check_hv("stall_am_hv", am_hv, q2);
            tick();
        end
        am_ready = 1'b1;
        @(negedge clk);
        check("stall_release_am_valid", 64'(am_valid), 64'd1);
        tick();
        am_ready = 1'b0;
        @(negedge clk);
        check("stall_wait_am_valid", 64'(am_valid), 64'd0);
        check("stall_wait_am_ready_in", 64'(am_rin), 64'd1);

        // Reset while waiting for the AM result
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_tag", 64'(tag), 64'd0);
        check("midrst_dist_v", 64'(dvo), 64'd0);
        check_hv("midrst_am_hv", am_hv, '0);
        tick();
        run_one(4'b1001, got, ok);
        check("midrst_ptr_done", 64'(ok), 64'd1);
        check("midrst_ptr_tag", 64'(got), 64'd0);
        run_one(4'b1000, got, ok);
        check("midrst_req3_done", 64'(ok), 64'd1);
        check("midrst_req3_tag", 64'(got), 64'd3);

        // Randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            valid_in = N'($urandom);
            am_ready = ($urandom % 3) != 0;
            am_vout  = ($urandom % 2) != 0;
            ready_in = ($urandom % 4) != 0;
            la = LW'($urandom); lv = LW'($urandom);
            da = DW'($urandom); dv = DW'($urandom);
            if ($urandom % 4 == 0) fill_hv();
            rst = ($urandom % 250) == 0;
            tick();
        end
        rst = 1'b0; valid_in = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Pointer wrap with three requesters
        for (int w = 0; w < N3; w++) hv3[w*HV3 +: HV3] = HV3'($urandom);
        valid3 = 3'b100;
        @(negedge clk);
        check("wrap_ready_2", 64'(ready3), 64'h4);
        tick();
        valid3 = '0;
        tick();
        tick();
        @(negedge clk);
        s3 = hv3[2*HV3 +: HV3];
        check("wrap_valid_out_2", 64'(valid_out3), 64'd1);
        check("wrap_tag_2", 64'(tag3), 64'd2);
        check("wrap_hv_2", 64'(am_hv3), 64'(s3));
        tick();
        valid3 = 3'b101;
        @(negedge clk);
        check("wrap_ready_0", 64'(ready3), 64'h1);
        tick();
        valid3 = '0;
        tick();
        tick();
        @(negedge clk);
        check("wrap_valid_out_0", 64'(valid_out3), 64'd1);
        check("wrap_tag_0", 64'(tag3), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am_query_arbiter.md
Name: am_query_arbiter

Overview:
- Shares one non-pipelined associative_memory instance between NUM_REQ query sources (e.g. per-window encoders).
- Arbitrates requesters round-robin, buffers the granted query hypervector and sequences the AM valid/ready handshake.
- Captures the AM A/V labels and distances, returns them tagged with the requester index.
- Sits between the encoder stage(s) and the AM. Only one query is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TAG_WIDTH, 2, ceilLog2(NUM_REQ)
- HV_DIMENSION, 2000, hypervector width in bits
- LABEL_WIDTH, 1, AM label width
- DISTANCE_WIDTH, 11, AM distance width

Ports:
- Clk_CI  in  1  clock; single clock domain
- Reset_RI  in  1  synchronous, active-high reset
- ValidIn_SI  in  NUM_REQ  per-requester query valid
- ReadyOut_SO  out  NUM_REQ  per-requester accept; one-hot or zero
- HypervectorIn_DI  in  NUM_REQ*HV_DIMENSION  packed queries; requester i occupies slice i
- AmValid_SO  out  1  query valid to AM
- AmReady_SI  in  1  AM ready for a query
- AmHypervector_DO  out  HV_DIMENSION  buffered query to AM
- AmValidOut_SI  in  1  AM result valid
- AmReadyIn_SO  out  1  arbiter accepts AM result
- AmLabel_A_DI, AmLabel_V_DI  in  LABEL_WIDTH  AM labels
- AmDistance_A_DI, AmDistance_V_DI  in  DISTANCE_WIDTH  AM distances
- ValidOut_SO  out  1  tagged result valid
- ReadyIn_SI  in  1  downstream accepts result
- TagOut_DO  out  TAG_WIDTH  index of the originating requester
- LabelOut_A_DO, LabelOut_V_DO  out  LABEL_WIDTH  result labels
- DistanceOut_A_DO, DistanceOut_V_DO  out  DISTANCE_WIDTH  result distances
- Busy_SO  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset_RI high at a clock edge):
  - state=IDLE, RR pointer=0.
  - Query buffer, tag register and all result registers = 0.
  - All valid/ready outputs = 0, except ReadyOut_SO, which is combinational per the rules below.
- IDLE:
  - Grant g = first i with ValidIn_SI[i]=1, searching from the pointer upward with wrap to 0.
  - ReadyOut_SO = one-hot(g) combinationally; 0 if no request is valid.
  - On a grant: capture slice g into the query buffer and g into the tag, set pointer=(g+1) mod NUM_REQ, go to ISSUE.
  - No request: stay in IDLE; pointer unchanged.
- ISSUE:
  - AmValid_SO=1; AmHypervector_DO = query buffer, stable from ISSUE until return to IDLE.
  - When AmReady_SI=1, go to WAIT_RES. Otherwise hold AmValid_SO and data.
- WAIT_RES:
  - AmReadyIn_SO=1.
  - When AmValidOut_SI=1: capture both labels and both distances, go to DELIVER.
  - No timeout; waits indefinitely.
- DELIVER:
  - ValidOut_SO=1 with tag and result held stable.
  - When ReadyIn_SI=1, go to IDLE.
  - New requests are not accepted until the cycle after (one bubble per query).
- ReadyOut_SO is 0 in every state except IDLE.
- Minimum latency from grant edge to ValidOut_SO: 2 cycles plus AM compute time.
- A requester deasserting ValidIn_SI while not granted is legal; it loses no state.
- All NUM_REQ valid continuously: grants follow pointer order 0,1,2,3,0,… with no starvation.
- NUM_REQ not a power of two: pointer wraps at NUM_REQ-1→0. Tag values ≥NUM_REQ never occur.
- Reset mid-operation: abandons any in-flight query and returns to IDLE. The AM must be reset by the same Reset_RI.
- AmValidOut_SI outside WAIT_RES: ignored; result registers unchanged.

Optional Feature:
- Macro: AM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins. The pointer register is removed and TagOut_DO = granted index.
- Undefined: round-robin as specified above.
- Port list is identical in both builds.

Decomposition:
- const.vh additions: state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT_RES=2'd2, ARB_DELIVER=2'd3; AM_ARB_NUM_REQ; AM_ARB_TAG_WIDTH; existing ceilLog2 macro.
- One sub-module: rr_arbiter. Combinational one-hot grant from a request vector and pointer; the pointer input is tied to 0 when AM_ARB_FIXED_PRIO_EN is defined.

Test Plan:
- Single request: ValidIn_SI=4'b0100 with query Q, AM model returns labels 1/0 and distances 37/912 → AmHypervector_DO=Q; ValidOut_SO with TagOut_DO=2, LabelOut_A_DO=1, LabelOut_V_DO=0, DistanceOut_A_DO=37, DistanceOut_V_DO=912.
- Contention: ValidIn_SI=4'b1111 held for 8 queries → grant order 0,1,2,3,0,1,2,3; exactly one ReadyOut_SO bit high per grant. With AM_ARB_FIXED_PRIO_EN defined → all 8 grants go to 0.
- Backpressure: ReadyIn_SI=0 for 20 cycles in DELIVER → outputs held, ReadyOut_SO=0, Busy_SO=1. On ReadyIn_SI=1 → IDLE next cycle, new grant one cycle later.
- AM stall: AmReady_SI=0 for 5 cycles in ISSUE → AmValid_SO stays 1 with stable data; transition to WAIT_RES only on the AmReady_SI=1 cycle.
- Reset in WAIT_RES → next cycle state=IDLE, ValidOut_SO=0, all result outputs 0, pointer 0; next request from requester 3 → TagOut_DO=3.
- Wrap: NUM_REQ=3; requesters 2 then 0 request → tags 2 then 0; pointer wraps to 0 after 2.
